// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter (8N1, LSB first, idle high).
// Requesters A and B offer bytes with valid/ready; the winner is picked in
// IDLE, with packet-level locking (a byte with last=0 keeps the line for the
// same requester) and round-robin between packets when both compete.
//
// Handshake: a byte moves on a rising edge where x_valid=1 and x_ready=1.
// x_ready is only raised in IDLE, only for the selected requester, and at most
// once per IDLE visit, because acceptance moves the FSM to START immediately.
// The source may change x_data/x_last after that edge without affecting the
// byte in flight.
module uart_tx_arbiter #(
    parameter int DELAY_FRAMES = 234
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic [7:0] a_data,
    input  logic [7:0] b_data,
    input  logic       a_last,
    input  logic       b_last,
    output logic       a_ready,
    output logic       b_ready,
    output logic       uart_tx,
    output logic [1:0] grant,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Bit-period length widened by one bit so counter+1 never overflows.
    localparam logic [12:0] DF_W = 13'(DELAY_FRAMES);

    state_t      state;
    logic [11:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        cur_b;      // owner of the byte in flight (1 = B)
    logic        lock_held;  // a packet is open
    logic        lock_b;     // owner of the open packet (1 = B)
    logic        prefer_b;   // B wins a tie between fresh packets
    logic        tx_q;

    logic        win_b;
    logic        win_valid;
    logic        in_idle;
    logic        accept;
    logic        bit_done;
    logic [7:0]  sel_data;
    logic        sel_last;

    // Pick the requester that may send in IDLE: lock owner, sole requester, or round-robin.
    always_comb begin
        win_b     = 1'b0;
        win_valid = 1'b0;
        if (lock_held) begin
            win_b     = lock_b;
            win_valid = lock_b ? b_valid : a_valid;
        end else if (a_valid && b_valid) begin
            win_b     = prefer_b;
            win_valid = 1'b1;
        end else begin
            win_b     = b_valid;
            win_valid = a_valid | b_valid;
        end
    end

    // Ready is gated by reset so both readies are low the moment reset asserts.
    assign in_idle  = (state == IDLE) && sys_rst_n;
    assign a_ready  = in_idle && win_valid && !win_b;
    assign b_ready  = in_idle && win_valid && win_b;
    assign accept   = in_idle && win_valid;
    assign sel_data = win_b ? b_data : a_data;
    assign sel_last = win_b ? b_last : a_last;
    assign bit_done = ({1'b0, cnt} + 13'd1) == DF_W;

    // Transmit FSM, arbitration bookkeeping and registered serial output.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            cur_b     <= 1'b0;
            lock_held <= 1'b0;
            lock_b    <= 1'b0;
            prefer_b  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q    <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (accept) begin
                        shift     <= sel_data;
                        cur_b     <= win_b;
                        // Only the first byte of a packet moves the round-robin pointer.
                        if (!lock_held) begin
                            prefer_b <= !win_b;
                        end
                        lock_held <= !sel_last;
                        lock_b    <= win_b;
                        tx_q      <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        tx_q  <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx_q    <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx_q    <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uart_tx   = tx_q;
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign grant     = (state != IDLE) ? (cur_b ? 2'b10 : 2'b01) :
                       lock_held       ? (lock_b ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a 4-cycle bit period.
module tb_uart_tx_arbiter;

  localparam int DF    = 4;
  localparam int FRAME = 10 * DF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_last = 1'b0, b_last = 1'b0;
  logic       a_ready, b_ready, uart_tx, busy;
  logic [1:0] grant, state_dbg;

  uart_tx_arbiter #(.DELAY_FRAMES(DF)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .a_data    (a_data),
    .b_data    (b_data),
    .a_last    (a_last),
    .b_last    (b_last),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .uart_tx   (uart_tx),
    .grant     (grant),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The line is described by the time elapsed since the accepting edge:
  // 1..DF start bit, then 8 data bits of DF cycles each, then DF stop cycles.
  int         m_elapsed  = 0;
  logic [7:0] m_byte     = 8'h00;
  logic       m_cur_b    = 1'b0;
  logic       m_locked   = 1'b0;
  logic       m_lock_b   = 1'b0;
  logic       m_prefer_b = 1'b0;
  int         cyc        = 0;
  logic [7:0] exp_q[$];   // bytes expected on the line, in order

  logic       s_a_ready, s_b_ready, s_acc;
  logic [1:0] s_grant;

  task automatic model_reset();
    m_elapsed  = 0;
    m_locked   = 1'b0;
    m_lock_b   = 1'b0;
    m_prefer_b = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: compare outputs with the model at negedge, advance to posedge+1.
  task automatic cycle();
    logic       e_ar, e_br, e_busy, e_tx, win_b, have, lst;
    logic [1:0] e_gr;
    logic [7:0] got_byte;
    @(negedge clk);
    s_a_ready = a_ready;
    s_b_ready = b_ready;
    s_grant   = grant;
    s_acc     = 1'b0;
    win_b     = 1'b0;
    have      = 1'b0;
    if (m_elapsed == 0) begin
      if (m_locked) begin
        win_b = m_lock_b;
        have  = m_lock_b ? b_valid : a_valid;
      end else if (a_valid && b_valid) begin
        win_b = m_prefer_b;
        have  = 1'b1;
      end else begin
        win_b = b_valid;
        have  = a_valid | b_valid;
      end
      e_ar   = have && !win_b;
      e_br   = have && win_b;
      e_busy = 1'b0;
      e_tx   = 1'b1;
      e_gr   = m_locked ? (m_lock_b ? 2'b10 : 2'b01) : 2'b00;
    end else begin
      e_ar   = 1'b0;
      e_br   = 1'b0;
      e_busy = 1'b1;
      e_gr   = m_cur_b ? 2'b10 : 2'b01;
      if (m_elapsed <= DF) e_tx = 1'b0;
      else if (m_elapsed <= 9 * DF) e_tx = m_byte[(m_elapsed - DF - 1) / DF];
      else e_tx = 1'b1;
    end
    check("cycle {a_ready,b_ready,busy,grant,uart_tx}",
          {26'd0, a_ready, b_ready, busy, grant, uart_tx},
          {26'd0, e_ar, e_br, e_busy, e_gr, e_tx});
    if (m_elapsed == 0) begin
      if (have) begin
        m_byte  = win_b ? b_data : a_data;
        lst     = win_b ? b_last : a_last;
        m_cur_b = win_b;
        if (!m_locked) m_prefer_b = !win_b;
        m_locked  = !lst;
        m_lock_b  = win_b;
        m_elapsed = 1;
        s_acc     = 1'b1;
        exp_q.push_back(m_byte);
      end
    end else if (m_elapsed == FRAME) begin
      m_elapsed = 0;
      got_byte  = exp_q.pop_front();
    end else begin
      m_elapsed++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       a_v, b_v, a_l, b_l;
    logic [7:0] a_d, b_d;
    logic       exp_ar, exp_br;
    logic [1:0] exp_gr;
  } vec_t;

  vec_t tbl[10];

  // ---------------- stimulus ----------------
  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int acc_cyc[3];
    int n_acc;
    int b_rdy_cnt;
    logic got;

    //                a_v   b_v   a_l   b_l   a_d     b_d     ar    br    gr
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1, 1'b0, 2'b01};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 8'hA5, 1'b0, 1'b1, 2'b10};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h18, 1'b1, 1'b0, 2'b01};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b1, 2'b10};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 2'b01};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 2'b10};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hE7, 8'h7E, 1'b1, 1'b0, 2'b01};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 2'b01};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 8'h77, 1'b1, 1'b0, 2'b01};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 2'b10};

    // Reset state, with both requesters already offering.
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs {a_ready,b_ready,busy,grant,uart_tx}",
          {27'd0, a_ready, b_ready, busy, grant, uart_tx}, 32'b0_0_0_00_1);
    check("reset state_dbg", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;

    // Table: first entry is accepted on the first edge after release.
    for (int i = 0; i < 10; i++) begin
      a_valid = tbl[i].a_v;
      b_valid = tbl[i].b_v;
      a_last  = tbl[i].a_l;
      b_last  = tbl[i].b_l;
      a_data  = tbl[i].a_d;
      b_data  = tbl[i].b_d;
      cycle();
      check($sformatf("tbl[%0d] a_ready", i), {31'd0, s_a_ready}, {31'd0, tbl[i].exp_ar});
      check($sformatf("tbl[%0d] b_ready", i), {31'd0, s_b_ready}, {31'd0, tbl[i].exp_br});
      a_valid = 1'b0;
      b_valid = 1'b0;
      cycle();
      check($sformatf("tbl[%0d] grant", i), {30'd0, s_grant}, {30'd0, tbl[i].exp_gr});
      run(8);
      // Scramble the offered bytes while the latched byte is on the line.
      a_data = 8'($urandom);
      b_data = 8'($urandom);
      a_last = 1'($urandom);
      run(FRAME - 9);
    end

    // Locked 3-byte packet from A with gaps, B continuously requesting.
    b_valid   = 1'b1;
    b_data    = 8'h99;
    b_last    = 1'b1;
    b_rdy_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      a_valid = 1'b1;
      a_data  = 8'(k);
      a_last  = (k == 3);
      got     = 1'b0;
      for (int w = 0; w < 100 && !got; w++) begin
        cycle();
        if (s_b_ready) b_rdy_cnt++;
        got = s_a_ready;
      end
      check($sformatf("packet byte %0d accepted", k), {31'd0, got}, 32'd1);
      a_valid = 1'b0;
      for (int w = 0; w < FRAME + ((k < 3) ? 10 : 0); w++) begin
        if (w == 12) a_data = 8'($urandom);
        cycle();
        if (s_b_ready) b_rdy_cnt++;
      end
    end
    check("b_ready pulses during A packet", b_rdy_cnt, 0);
    cycle();
    check("B served after packet", {31'd0, s_b_ready}, 32'd1);
    b_valid = 1'b0;
    run(FRAME);

    // Back-to-back B bytes: accept spacing must be one frame plus one IDLE cycle.
    b_valid = 1'b1;
    b_data  = 8'hFF;
    b_last  = 1'b1;
    n_acc   = 0;
    for (int w = 0; w < 200 && n_acc < 3; w++) begin
      cycle();
      if (s_b_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
    end
    b_valid = 1'b0;
    check("back-to-back accept count", n_acc, 3);
    if (n_acc == 3) begin
      check("accept spacing 1", acc_cyc[1] - acc_cyc[0], FRAME + 1);
      check("accept spacing 2", acc_cyc[2] - acc_cyc[1], FRAME + 1);
    end
    run(FRAME);

    // Reset in the middle of a byte, then a fresh byte after release.
    a_valid = 1'b1;
    a_data  = 8'hC3;
    a_last  = 1'b1;
    cycle();
    check("pre-reset accept", {31'd0, s_a_ready}, 32'd1);
    run(14);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset {a_ready,b_ready,busy,grant,uart_tx}",
          {27'd0, a_ready, b_ready, busy, grant, uart_tx}, 32'b0_0_0_00_1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("held reset uart_tx", {31'd0, uart_tx}, 32'd1);
    rst_n  = 1'b1;
    a_data = 8'hA5;
    cycle();
    check("first accept after reset", {31'd0, s_a_ready}, 32'd1);
    a_valid = 1'b0;
    run(FRAME);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      a_valid = ($urandom_range(0, 2) != 0);
      b_valid = ($urandom_range(0, 2) != 0);
      a_data  = 8'($urandom);
      b_data  = 8'($urandom);
      a_last  = ($urandom_range(0, 2) != 0);
      b_last  = ($urandom_range(0, 2) != 0);
      cycle();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    run(2 * FRAME);
    check("line idle at end", {31'd0, uart_tx}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
